// File: rtl/snake_stream_sched.sv
// snake_stream_sched
//   Segment-memory controller and scheduler for the snake renderer. Owns the
//   snake body ring buffer held in an external single-port RAM (1-cycle read
//   latency), keeps the head pointer and length, and arbitrates the RAM port
//   between move/grow updates and a per-scanline replay stream.
//
// Optional feature macro: SNAKE_SCHED_RESTART_EN
//   defined   : line_start during STREAM aborts and restarts the pass at idx 0
//   undefined : line_start during STREAM is ignored; the pass completes
//   Either way the sticky overrun flag is set.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   game_rst_n            synchronous active-low game restart
//   line_start            one-cycle scanline start pulse
//   upd_req/upd_grow      move request (held until upd_ack), grow qualifier
//   upd_x/upd_y/upd_dir   new head segment
//   upd_ack               one-cycle pulse when the update is written
//   mem_addr/we/wdata     RAM port, word = {x[10:6], y[5:2], dir[1:0]}
//   mem_rdata             RAM read data
//   snake_head_x/y        current head position
//   snake_x/y/dir         streamed segment, qualified by snake_valid
//   snake_first/last      streamed segment is head / tail
//   length                current segment count, 1..MAX_LEN
//   full, overrun         sticky status flags
module snake_stream_sched #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned START_X = 4,
  parameter int unsigned START_Y = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_rst_n,
  input  logic              line_start,
  input  logic              upd_req,
  input  logic              upd_grow,
  input  logic [4:0]        upd_x,
  input  logic [3:0]        upd_y,
  input  logic [1:0]        upd_dir,
  output logic              upd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [10:0]       mem_wdata,
  input  logic [10:0]       mem_rdata,
  output logic [4:0]        snake_head_x,
  output logic [3:0]        snake_head_y,
  output logic [4:0]        snake_x,
  output logic [3:0]        snake_y,
  output logic [1:0]        snake_dir,
  output logic              snake_first,
  output logic              snake_last,
  output logic              snake_valid,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic              overrun
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STREAM, S_UPDATE} state_t;

  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [4:0]        INIT_X    = 5'(START_X);
  localparam logic [3:0]        INIT_Y    = 4'(START_Y);
  localparam logic [10:0]       INIT_WORD = {INIT_X, INIT_Y, 2'b00};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] head_ptr;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              pend;
  logic              is_last;
  logic              restart;

  assign is_last = ({1'b0, idx} == (length - LEN_ONE));

`ifdef SNAKE_SCHED_RESTART_EN
  assign restart = line_start;
`else
  assign restart = 1'b0;
`endif

  // Segment data comes straight from the RAM output register, which lines up
  // with the registered valid/first/last; zeroed when not qualified.
  assign snake_x   = snake_valid ? mem_rdata[10:6] : '0;
  assign snake_y   = snake_valid ? mem_rdata[5:2]  : '0;
  assign snake_dir = snake_valid ? mem_rdata[1:0]  : '0;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    upd_ack   = 1'b0;
    case (state)
      S_INIT: begin
        // No RAM write while the asynchronous reset is still held.
        mem_we    = rst_n;
        mem_wdata = INIT_WORD;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (line_start || pend) begin
          state_nxt = S_STREAM;
          idx_nxt   = '0;
        end else if (upd_req) begin
          state_nxt = S_UPDATE;
        end
      end
      S_STREAM: begin
        mem_addr = head_ptr - idx;
        if (restart) begin
          idx_nxt = '0;
        end else if (is_last) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt = idx + PTR_ONE;
        end
      end
      S_UPDATE: begin
        mem_addr  = head_ptr + PTR_ONE;
        mem_we    = 1'b1;
        mem_wdata = {upd_x, upd_y, upd_dir};
        upd_ack   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
    if (!game_rst_n) begin
      state_nxt = S_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr     <= '0;
      length       <= LEN_ONE;
      full         <= 1'b0;
      overrun      <= 1'b0;
      pend         <= 1'b0;
      snake_head_x <= INIT_X;
      snake_head_y <= INIT_Y;
      snake_valid  <= 1'b0;
      snake_first  <= 1'b0;
      snake_last   <= 1'b0;
    end else begin
      snake_valid <= (state == S_STREAM) && game_rst_n;
      snake_first <= (state == S_STREAM) && game_rst_n && (idx == '0);
      snake_last  <= (state == S_STREAM) && game_rst_n && is_last && !restart;
      // Game state is cleared both on the restart edge and throughout INIT so
      // the INIT cycle already shows the restarted values.
      if (!game_rst_n || state == S_INIT) begin
        head_ptr     <= '0;
        length       <= LEN_ONE;
        full         <= 1'b0;
        overrun      <= 1'b0;
        pend         <= 1'b0;
        snake_head_x <= INIT_X;
        snake_head_y <= INIT_Y;
      end else begin
        if (state == S_UPDATE) begin
          head_ptr     <= head_ptr + PTR_ONE;
          snake_head_x <= upd_x;
          snake_head_y <= upd_y;
          if (upd_grow) begin
            if (length == LEN_MAX) begin
              full <= 1'b1;
            end else begin
              length <= length + LEN_ONE;
            end
          end
        end
        if (state == S_STREAM && line_start) begin
          overrun <= 1'b1;
        end
        if (state == S_UPDATE && line_start) begin
          pend <= 1'b1;
        end else if (state == S_IDLE) begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule
